conv_line_feeder: RTL
=====================

Name: conv_line_feeder

Overview:
- Supply side of the convolution datapath's `shift_buffer` / `in_l1..in_l3` interface.
- Accepts a raster pixel stream and buffers three image rows in a rotating line buffer.
- On each `shift_buffer` request from the convolution engine, presents the next vertical 3-pixel column.
- Advances the window down the frame by the programmed stride and flags row and frame completion.

Parameters:
- BIT_DEPTH, 8, pixel width in bits
- IMG_W, 8, image width in pixels (minimum 2)
- IMG_H, 8, image height in rows (minimum 3)
- COL_W, 3, counter width for column index; must be at least clog2(IMG_W)
- ROW_W, 4, counter width for row index; must hold IMG_H+2

Ports:
- clk, input, 1, system clock; all state updates on the rising edge
- rst_n, input, 1, reset, asynchronous and active-low
- start, input, 1, one-cycle pulse that begins a frame; honoured only in IDLE
- stride, input, 2, vertical window step; latched on the accepted `start`; 0 is treated as 1
- pix_in, input, BIT_DEPTH, raster pixel data
- pix_valid, input, 1, `pix_in` is valid
- pix_ready, output, 1, feeder can accept a pixel; transfer occurs when `pix_valid && pix_ready`
- shift_buffer, input, 1, request for the next column, from the convolution engine
- in_l1, output, BIT_DEPTH, pixel from the top (oldest) window row
- in_l2, output, BIT_DEPTH, pixel from the middle window row
- in_l3, output, BIT_DEPTH, pixel from the bottom (newest) window row
- col_valid, output, 1, `in_l1..in_l3` hold a column of the current window
- row_done, output, 1, one-cycle pulse: all IMG_W columns of the window have been consumed
- frame_done, output, 1, one-cycle pulse: last window of the frame has been consumed
- busy, output, 1, high in every state except IDLE

Behaviour:
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - `in_l1..in_l3`, `col_valid`, `row_done`, `frame_done`, `pix_ready` and `busy` are all 0.
  - Counters, row pointer and latched stride are cleared; line-buffer contents are don't-care.
  - A reset mid-frame abandons the frame. No `frame_done` is issued.
- States:
  - IDLE:
    - `start` latches `stride` and goes to FILL.
    - `top_row` = 0, `base` = 0.
  - FILL:
    - `pix_ready` = 1.
    - Accepts 3*IMG_W pixels into slots `base`, `base+1`, `base+2` (mod 3), column-major per row in raster order.
    - After the last accepted pixel, goes to SERVE with `col_idx` = 0 and `col_valid` = 0.
  - SERVE:
    - `pix_ready` = 0.
    - A `shift_buffer` pulse presents column `col_idx` on the next cycle (1-cycle registered latency), sets `col_valid`, and increments `col_idx`.
    - `in_l1` = slot `base`, `in_l2` = slot `base+1`, `in_l3` = slot `base+2`.
    - A `shift_buffer` pulse while `col_idx` == IMG_W (all columns already presented) does not change the outputs. It clears `col_valid` and pulses `row_done` next cycle.
    - It then moves to DONE if `top_row + s + 2 > IMG_H - 1` (where `s` is the effective stride); otherwise it moves to ADVANCE.
  - ADVANCE:
    - `pix_ready` = 1.
    - Accepts `s`*IMG_W pixels, overwriting the oldest `s` slots, starting at slot `base`.
    - When complete: `base` = (`base` + `s`) mod 3, `top_row` += `s`, `col_idx` = 0, go to SERVE.
  - DONE:
    - Pulses `frame_done` for one cycle, then goes to IDLE.
    - Remaining input rows are not consumed; the upstream source must drop them.
- `shift_buffer` is ignored in IDLE, FILL, ADVANCE and DONE. `start` is ignored outside IDLE.
- `in_l*` hold their last value until the next presented column.
- `pix_valid` gaps stall FILL/ADVANCE indefinitely with no timeout.
- A stride of 3 is legal: the window steps past rows without overlap and the whole buffer is reloaded.
- Pixel values pass through unmodified; no arithmetic on data.

Decomposition:
- Shared package `conv_pkg` holds:
  - the FSM state encoding (IDLE, FILL, SERVE, ADVANCE, DONE);
  - the effective-stride function (0→1);
  - a BIT_DEPTH default constant shared with the convolution engine.
- One sub-module, `line_buf_ram`: 3 x IMG_W register array with one write port and one 3-row read port at a common column.

Test Plan:
Bench uses IMG_W=4, IMG_H=4; pixel value = row*4+col, streamed with `pix_valid` held high unless noted.
- Stride 1:
  - After FILL, 1st shift gives `in_l1`=0, `in_l2`=4, `in_l3`=8 with `col_valid`=1.
  - 4th shift gives 3, 7, 11.
  - 5th shift gives a `row_done` pulse and `pix_ready`=1 for exactly 4 pixels (12..15).
  - Next shift gives 4, 8, 12.
- Stride 1 completion: after the second window's 4 columns, the next shift gives `row_done`, then `frame_done` one cycle later; `busy` drops to 0.
- Stride 2: single window (0/4/8 .. 3/7/11), then `row_done` and `frame_done`; no ADVANCE and `pix_ready` never reasserts. Stride 0 behaves identically to stride 1.
- Shifts during FILL and backpressure:
  - `shift_buffer` held high during FILL leaves `col_valid`=0 and `in_l*`=0.
  - `pix_valid` toggling every other cycle still yields the 1st column 0/4/8.
- Reset mid-frame: `rst_n` low during SERVE after 2 shifts clears all outputs immediately. A fresh `start` gives 0/4/8 again on the 1st shift, with no `frame_done` from the aborted frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: FSM encoding, stride and slot helpers.
// Pure declarations; no latency or flow-control implications.
package conv_pkg;

   localparam int CONV_BIT_DEPTH = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FILL    = 3'd1;
   localparam logic [2:0] ST_SERVE   = 3'd2;
   localparam logic [2:0] ST_ADVANCE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   function automatic logic [1:0] eff_stride(input logic [1:0] s);
      return (s == 2'd0) ? 2'd1 : s;
   endfunction

   // Modulo-3 slot arithmetic; b is always 0..2 and o at most 3, so one wrap suffices.
   function automatic logic [1:0] slot_add(input logic [1:0] b, input logic [1:0] o);
      logic [2:0] sum;
      sum = {1'b0, b} + {1'b0, o};
      if (sum >= 3'd3) begin
         sum = sum - 3'd3;
      end
      return sum[1:0];
   endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Three-row line store: one write port, combinational read of all rows at one column.
// Writes land on the rising edge; no flow control of its own.
module line_buf_ram #(
   parameter int BIT_DEPTH = 8,
   parameter int IMG_W     = 8,
   parameter int COL_W     = 3
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [1:0]                wr_row,
   input  logic [COL_W-1:0]          wr_col,
   input  logic [BIT_DEPTH-1:0]      wr_dat,
   input  logic [COL_W-1:0]          rd_col,
   output logic [2:0][BIT_DEPTH-1:0] rd_dat
);

   logic [BIT_DEPTH-1:0] mem [3][IMG_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_row][wr_col] <= wr_dat;
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         rd_dat[r] = mem[r][rd_col];
      end
   end

endmodule

// File: rtl/conv_line_feeder.sv
// Buffers three raster rows and serves 3-pixel columns on shift_buffer, 1-cycle registered latency.
// pix_ready high only while loading (FILL/ADVANCE); pix_valid gaps stall loading without limit.
module conv_line_feeder
   import conv_pkg::*;
#(
   parameter int BIT_DEPTH = CONV_BIT_DEPTH,
   parameter int IMG_W     = 8,
   parameter int IMG_H     = 8,
   parameter int COL_W     = 3,
   parameter int ROW_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [1:0]           stride,
   input  logic [BIT_DEPTH-1:0] pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic                 shift_buffer,
   output logic [BIT_DEPTH-1:0] in_l1,
   output logic [BIT_DEPTH-1:0] in_l2,
   output logic [BIT_DEPTH-1:0] in_l3,
   output logic                 col_valid,
   output logic                 row_done,
   output logic                 frame_done,
   output logic                 busy
);

   localparam logic [COL_W:0]   COL_END  = (COL_W+1)'(IMG_W);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W:0]   LAST_ROW = (ROW_W+1)'(IMG_H - 1);

   logic [2:0]                 state;
   logic [1:0]                 stride_q;
   logic [1:0]                 base;
   logic [ROW_W-1:0]           top_row;
   logic [COL_W:0]             col_idx;
   logic [COL_W-1:0]           wr_col;
   logic [1:0]                 wr_row;

   logic                       accept;
   logic [1:0]                 rows_needed;
   logic                       wr_last;
   logic [1:0]                 wr_slot;
   logic [2:0][BIT_DEPTH-1:0]  rd_dat;
   logic [ROW_W:0]             next_bottom;
   logic                       frame_end;

   assign busy        = (state != ST_IDLE);
   assign pix_ready   = (state == ST_FILL) || (state == ST_ADVANCE);
   assign accept      = pix_valid && pix_ready;
   assign rows_needed = (state == ST_FILL) ? 2'd3 : stride_q;
   assign wr_last     = (wr_col == LAST_COL) && (wr_row == rows_needed - 2'd1);
   assign wr_slot     = slot_add(base, wr_row);

   // Bottom row of the window after one more step; past the last image row ends the frame.
   assign next_bottom = {1'b0, top_row} + {{(ROW_W-1){1'b0}}, stride_q} + (ROW_W+1)'(2);
   assign frame_end   = (next_bottom > LAST_ROW);

   line_buf_ram #(
      .BIT_DEPTH (BIT_DEPTH),
      .IMG_W     (IMG_W),
      .COL_W     (COL_W)
   ) u_line_buf_ram (
      .clk    (clk),
      .wr_en  (accept),
      .wr_row (wr_slot),
      .wr_col (wr_col),
      .wr_dat (pix_in),
      .rd_col (col_idx[COL_W-1:0]),
      .rd_dat (rd_dat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         stride_q   <= 2'd0;
         base       <= 2'd0;
         top_row    <= '0;
         col_idx    <= '0;
         wr_col     <= '0;
         wr_row     <= 2'd0;
         in_l1      <= '0;
         in_l2      <= '0;
         in_l3      <= '0;
         col_valid  <= 1'b0;
         row_done   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         row_done   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  stride_q  <= eff_stride(stride);
                  top_row   <= '0;
                  base      <= 2'd0;
                  wr_col    <= '0;
                  wr_row    <= 2'd0;
                  col_idx   <= '0;
                  col_valid <= 1'b0;
                  state     <= ST_FILL;
               end
            end
            ST_FILL, ST_ADVANCE: begin
               if (accept) begin
                  if (wr_last) begin
                     wr_col    <= '0;
                     wr_row    <= 2'd0;
                     col_idx   <= '0;
                     col_valid <= 1'b0;
                     if (state == ST_ADVANCE) begin
                        base    <= slot_add(base, stride_q);
                        top_row <= top_row + ROW_W'(stride_q);
                     end
                     state <= ST_SERVE;
                  end else if (wr_col == LAST_COL) begin
                     wr_col <= '0;
                     wr_row <= wr_row + 2'd1;
                  end else begin
                     wr_col <= wr_col + COL_W'(1);
                  end
               end
            end
            ST_SERVE: begin
               if (shift_buffer) begin
                  if (col_idx != COL_END) begin
                     in_l1     <= rd_dat[base];
                     in_l2     <= rd_dat[slot_add(base, 2'd1)];
                     in_l3     <= rd_dat[slot_add(base, 2'd2)];
                     col_valid <= 1'b1;
                     col_idx   <= col_idx + (COL_W+1)'(1);
                  end else begin
                     // Extra shift after the last column closes the window row.
                     col_valid <= 1'b0;
                     row_done  <= 1'b1;
                     state     <= frame_end ? ST_DONE : ST_ADVANCE;
                  end
               end
            end
            ST_DONE: begin
               frame_done <= 1'b1;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
